// File: rtl/rle_stream_encoder.sv
// Run-length encoder for 64-coefficient blocks with one registered output word.
// Ports: coef in (i_coefValid/o_coefReady), stream out (o_dataValid/i_dataReady), status pulses.
module rle_stream_encoder (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_coefValid,
  output logic        o_coefReady,
  input  logic [9:0]  i_coef,
  input  logic [5:0]  i_scale,
  output logic        o_dataValid,
  input  logic        i_dataReady,
  output logic [15:0] o_dataOut,
  output logic        o_blockDone,
  output logic        o_dcClamped
);

  typedef enum logic [1:0] {
    DC   = 2'd0,
    AC   = 2'd1,
    FULL = 2'd2,
    EOB  = 2'd3
  } state_t;

  localparam logic [15:0] EobWord = 16'hFE00;
  localparam logic [15:0] DcAlias = 16'hFE01;

  state_t      state;
  state_t      nextState;
  logic [5:0]  idx;
  logic [5:0]  run;
  logic        lastWord;

  logic        canLoad;
  logic        inXfer;
  logic        idxLast;
  logic        coefZero;
  logic        load;
  logic [15:0] loadWord;
  logic        loadLast;
  logic        loadClamp;
  logic [15:0] dcWord;

  assign canLoad  = !o_dataValid || i_dataReady;
  assign idxLast  = (idx == 6'd63);
  assign coefZero = (i_coef == 10'd0);
  assign dcWord   = {i_scale, i_coef};

  // Accept only when the output register can take a word next edge.
  assign o_coefReady = !i_rst && (state != EOB) && canLoad;
  assign inXfer      = i_coefValid && o_coefReady;

  // Last-word flag travels with the registered word.
  assign o_blockDone = !i_rst && o_dataValid && i_dataReady && lastWord;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= DC;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      DC: begin
        if (inXfer) begin
          nextState = (i_scale == 6'd0) ? FULL : AC;
        end
      end
      AC: begin
        if (inXfer && idxLast) begin
          nextState = coefZero ? EOB : DC;
        end
      end
      FULL: begin
        if (inXfer && idxLast) begin
          nextState = DC;
        end
      end
      EOB: begin
        if (canLoad) begin
          nextState = DC;
        end
      end
      default: nextState = DC;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    loadWord  = 16'h0000;
    loadLast  = 1'b0;
    loadClamp = 1'b0;
    unique case (state)
      DC: begin
        if (inXfer) begin
          load = 1'b1;
          // A DC word equal to the end marker would end the block early.
          if (dcWord == EobWord) begin
            loadWord  = DcAlias;
            loadClamp = 1'b1;
          end else begin
            loadWord = dcWord;
          end
        end
      end
      AC: begin
        if (inXfer && !coefZero) begin
          load     = 1'b1;
          loadWord = {run, i_coef};
          loadLast = idxLast;
        end
      end
      FULL: begin
        if (inXfer) begin
          load     = 1'b1;
          loadWord = {6'd0, i_coef};
          loadLast = idxLast;
        end
      end
      EOB: begin
        if (canLoad) begin
          load     = 1'b1;
          loadWord = EobWord;
          loadLast = 1'b1;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      idx <= 6'd0;
      run <= 6'd0;
    end else if (inXfer) begin
      idx <= idx + 6'd1;
      if (state == AC && coefZero) begin
        run <= run + 6'd1;
      end else begin
        run <= 6'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_dataValid <= 1'b0;
      o_dataOut   <= 16'h0000;
      lastWord    <= 1'b0;
      o_dcClamped <= 1'b0;
    end else begin
      o_dcClamped <= load && loadClamp;
      if (load) begin
        o_dataValid <= 1'b1;
        o_dataOut   <= loadWord;
        lastWord    <= loadLast;
      end else if (i_dataReady) begin
        o_dataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Scoreboard bench for rle_stream_encoder.
// Directed blocks; a negedge monitor pops expected words on each transfer.
module tb_rle_stream_encoder;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_coefValid;
  logic        o_coefReady;
  logic [9:0]  i_coef;
  logic [5:0]  i_scale;
  logic        o_dataValid;
  logic        i_dataReady;
  logic [15:0] o_dataOut;
  logic        o_blockDone;
  logic        o_dcClamped;

  always #5 clk = ~clk;

  rle_stream_encoder dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_coefValid (i_coefValid),
    .o_coefReady (o_coefReady),
    .i_coef      (i_coef),
    .i_scale     (i_scale),
    .o_dataValid (o_dataValid),
    .i_dataReady (i_dataReady),
    .o_dataOut   (o_dataOut),
    .o_blockDone (o_blockDone),
    .o_dcClamped (o_dcClamped)
  );

  typedef struct {
    logic [15:0] w;
    logic        last;
  } exp_t;

  exp_t       q[$];
  int         nVec = 0;
  int         nFail = 0;
  int         nClamp = 0;
  int         nDone = 0;
  int         sentCount = 0;
  logic [9:0] blk[64];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [15:0] w, input logic l);
    exp_t e;
    e.w = w;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic clrBlk();
    for (int i = 0; i < 64; i++) blk[i] = 10'd0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic sendCoef(input logic [9:0] c, input logic [5:0] s);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_coefValid = 1'b1;
    i_coef = c;
    i_scale = s;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = o_coefReady;
      @(posedge clk);
      #1;
      n++;
    end
    i_coefValid = 1'b0;
    if (!acc) begin
      nVec++;
      nFail++;
      $display("FAIL coefAccept: timeout got ready=0 required 1");
    end
  endtask

  // Scale is driven with junk after index 0; it must be ignored.
  task automatic sendBlock(input logic [5:0] s);
    for (int i = 0; i < 64; i++) begin
      sendCoef(blk[i], (i == 0) ? s : 6'h15);
      sentCount = i + 1;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drainPending", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!i_rst) begin
      if (o_dcClamped) begin
        nClamp++;
        chk("clampWord", o_dataOut, 16'hFE01);
      end
      if (o_dataValid && i_dataReady) begin
        if (q.size() == 0) begin
          nVec++;
          nFail++;
          $display("FAIL extraWord: got %0h required none", o_dataOut);
        end else begin
          e = q.pop_front();
          chk("word", o_dataOut, e.w);
          chk("blockDone", o_blockDone, e.last);
          if (o_blockDone) nDone++;
        end
      end else if (o_blockDone) begin
        nVec++;
        nFail++;
        $display("FAIL idleBlockDone: got 1 required 0");
      end
    end
  end

  task automatic stallProc();
    int n;
    n = 0;
    while (sentCount != 6 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("stallReached", sentCount, 6);
    i_dataReady = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stallValid", o_dataValid, 1);
      chk("stallData", o_dataOut, 16'h1003);
      chk("stallCoefReady", o_coefReady, 0);
    end
    @(posedge clk);
    #1;
    i_dataReady = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_coefValid = 1'b0;
    i_coef = 10'd0;
    i_scale = 6'd0;
    i_dataReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstValid", o_dataValid, 0);
    chk("rstData", o_dataOut, 0);
    chk("rstCoefReady", o_coefReady, 0);
    chk("rstDone", o_blockDone, 0);
    chk("rstClamp", o_dcClamped, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    clrBlk();
    blk[0] = 10'h010;
    blk[5] = 10'h003;
    pushExp(16'h0810, 1'b0);
    pushExp(16'h1003, 1'b0);
    pushExp(16'hFE00, 1'b1);
    sendBlock(6'd2);

    for (int k = 0; k < 64; k++) begin
      blk[k] = 10'(k);
      pushExp(16'(k), k == 63);
    end
    sendBlock(6'd0);

    clrBlk();
    blk[63] = 10'h001;
    pushExp(16'h0400, 1'b0);
    pushExp(16'hF801, 1'b1);
    sendBlock(6'd1);

    clrBlk();
    blk[0] = 10'h200;
    pushExp(16'hFE01, 1'b0);
    pushExp(16'hFE00, 1'b1);
    sendBlock(6'd63);
    waitDrain();
    chk("clampCount", nClamp, 1);

    clrBlk();
    blk[0] = 10'h010;
    blk[5] = 10'h003;
    pushExp(16'h0810, 1'b0);
    pushExp(16'h1003, 1'b0);
    pushExp(16'hFE00, 1'b1);
    sentCount = 0;
    fork
      sendBlock(6'd2);
      stallProc();
    join
    waitDrain();

    clrBlk();
    blk[0] = 10'h005;
    blk[9] = 10'h002;
    pushExp(16'h0C05, 1'b0);
    for (int i = 0; i < 9; i++) begin
      sendCoef(blk[i], (i == 0) ? 6'd3 : 6'h15);
    end
    waitDrain();
    i_dataReady = 1'b0;
    sendCoef(blk[9], 6'h15);
    @(negedge clk);
    chk("pendValid", o_dataValid, 1);
    chk("pendData", o_dataOut, 16'h2002);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(negedge clk);
    chk("midRstCoefReady", o_coefReady, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midRstValid", o_dataValid, 0);
    chk("midRstData", o_dataOut, 0);
    chk("midRstDone", o_blockDone, 0);
    chk("midRstClamp", o_dcClamped, 0);
    chk("midRstCoefReady2", o_coefReady, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    i_dataReady = 1'b1;

    clrBlk();
    blk[63] = 10'h001;
    pushExp(16'h0400, 1'b0);
    pushExp(16'hF801, 1'b1);
    sendBlock(6'd1);
    waitDrain();

    chk("doneCount", nDone, 6);
    chk("clampTotal", nClamp, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
